// File: rtl/coprocessor0_regfile_pkg.sv
// CP0 data types, register numbers and exception codes shared by the CP0
// register file, its timer and the writeback stage.
package coprocessor0_params;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned EXC_W  = 5;
  localparam int unsigned IP_W   = 8;

  localparam logic [REG_W-1:0] CP0_BADVADDR = 5'd8;
  localparam logic [REG_W-1:0] CP0_COUNT    = 5'd9;
  localparam logic [REG_W-1:0] CP0_COMPARE  = 5'd11;
  localparam logic [REG_W-1:0] CP0_STATUS   = 5'd12;
  localparam logic [REG_W-1:0] CP0_CAUSE    = 5'd13;
  localparam logic [REG_W-1:0] CP0_EPC      = 5'd14;

  localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_SYS  = 5'd8;
  localparam logic [EXC_W-1:0] EXC_BP   = 5'd9;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  // Bit positions of the mtc0-writable fields inside a raw write word
  localparam int unsigned STATUS_IE_BIT  = 0;
  localparam int unsigned STATUS_EXL_BIT = 1;
  localparam int unsigned STATUS_IM_LSB  = 8;
  localparam int unsigned CAUSE_IP_LSB   = 8;

  typedef struct packed {
    logic [8:0]    reserved_hi;
    logic          bev;
    logic [5:0]    reserved_mid;
    logic [IP_W-1:0] im;
    logic [5:0]    reserved_lo;
    logic          exl;
    logic          ie;
  } StatusData;

  typedef struct packed {
    logic             bd;
    logic             ti;
    logic [13:0]      reserved_hi;
    logic [IP_W-1:0]  ip;
    logic             reserved_mid;
    logic [EXC_W-1:0] exc_code;
    logic [1:0]       reserved_lo;
  } CauseData;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
  } EPCData;

  typedef struct packed {
    logic [REG_W-1:0]  address_register;
    logic [SEL_W-1:0]  address_select;
    logic              write_enabled;
    logic [DATA_W-1:0] write_data;
    logic              exception_valid;
    logic              eret_flush;
    logic [EXC_W-1:0]  exception_code;
    logic              in_delay_slot;
    logic [DATA_W-1:0] exception_pc;
    logic [DATA_W-1:0] bad_vaddr;
  } WBToCP0Bus;

  function automatic logic is_addr_error(input logic [EXC_W-1:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/coprocessor0_regfile_timer.sv
// CP0 Count/Compare timer: prescaled Count, Compare and the sticky timer
// interrupt (TI), which stays set until Compare is rewritten.
module coprocessor0_timer
  import coprocessor0_params::*;
#(
  parameter int unsigned COUNT_DIVIDE = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              count_write,
  input  logic              compare_write,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] count,
  output logic [DATA_W-1:0] compare,
  output logic              timer_interrupt
);

  localparam int unsigned PRE_W = (COUNT_DIVIDE > 1) ? $clog2(COUNT_DIVIDE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(COUNT_DIVIDE - 1);

  logic [PRE_W-1:0] prescaler;

  // Software writes win over the free-running increment and the TI set
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler       <= '0;
      count           <= '0;
      compare         <= '0;
      timer_interrupt <= 1'b0;
    end else begin
      if (count_write) begin
        count     <= write_data;
        prescaler <= '0;
      end else if (prescaler == PRE_LAST) begin
        prescaler <= '0;
        count     <= count + 32'd1;
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end

      if (compare_write) begin
        compare         <= write_data;
        timer_interrupt <= 1'b0;
      end else if (count == compare) begin
        timer_interrupt <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/coprocessor0_regfile.sv
// CP0 register file: Status, Cause, EPC, BadVAddr and (with CP0_TIMER_EN
// defined) the Count/Compare timer; serves mfc0 reads and interrupt_pending.
module coprocessor0_regfile
  import coprocessor0_params::*;
#(
  parameter int unsigned HW_INT_NUM   = 6,
  parameter int unsigned COUNT_DIVIDE = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  WBToCP0Bus             wb_bus,
  input  logic [HW_INT_NUM-1:0] hardware_interrupt,
  input  logic [REG_W-1:0]      read_register,
  input  logic [SEL_W-1:0]      read_select,
  output logic [DATA_W-1:0]     read_data,
  output StatusData             status,
  output CauseData              cause,
  output EPCData                epc,
  output logic                  interrupt_pending
);

  localparam int unsigned HW_MAX = 6;

  logic [HW_MAX-1:0]  hw_pad;
  logic [HW_MAX-1:0]  hw_ip;
  logic [1:0]         sw_ip;
  logic [IP_W-1:0]    status_im;
  logic               status_exl;
  logic               status_ie;
  logic               cause_bd;
  logic [EXC_W-1:0]   cause_exc;
  logic [DATA_W-1:0]  epc_q;
  logic [DATA_W-1:0]  badvaddr_q;
  logic [DATA_W-1:0]  count_value;
  logic [DATA_W-1:0]  compare_value;
  logic               timer_interrupt;

  // Absent interrupt lines read as 0 in Cause.IP
  for (genvar i = 0; i < HW_MAX; i++) begin : g_hw_pad
    if (i < HW_INT_NUM) begin : g_line
      assign hw_pad[i] = hardware_interrupt[i];
    end else begin : g_none
      assign hw_pad[i] = 1'b0;
    end
  end

  logic write_sel0;
  logic write_status;
  logic write_cause;
  logic write_epc;

  assign write_sel0   = wb_bus.write_enabled && (wb_bus.address_select == '0);
  assign write_status = write_sel0 && (wb_bus.address_register == CP0_STATUS);
  assign write_cause  = write_sel0 && (wb_bus.address_register == CP0_CAUSE);
  assign write_epc    = write_sel0 && (wb_bus.address_register == CP0_EPC);

`ifdef CP0_TIMER_EN
  logic write_count;
  logic write_compare;

  assign write_count   = write_sel0 && (wb_bus.address_register == CP0_COUNT);
  assign write_compare = write_sel0 && (wb_bus.address_register == CP0_COMPARE);

  coprocessor0_timer #(
    .COUNT_DIVIDE(COUNT_DIVIDE)
  ) u_timer (
    .clock          (clock),
    .reset          (reset),
    .count_write    (write_count),
    .compare_write  (write_compare),
    .write_data     (wb_bus.write_data),
    .count          (count_value),
    .compare        (compare_value),
    .timer_interrupt(timer_interrupt)
  );
`else
  logic unused_count_divide;

  assign count_value         = '0;
  assign compare_value       = '0;
  assign timer_interrupt     = 1'b0;
  assign unused_count_divide = (COUNT_DIVIDE == 0);
`endif

  // Exception owns Status/Cause/EPC for the cycle; eret owns Status only
  always_ff @(posedge clock) begin
    if (reset) begin
      hw_ip      <= '0;
      sw_ip      <= '0;
      status_im  <= '0;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
      cause_bd   <= 1'b0;
      cause_exc  <= '0;
      epc_q      <= '0;
      badvaddr_q <= '0;
    end else begin
      hw_ip <= hw_pad;
      if (wb_bus.exception_valid) begin
        if (!status_exl) begin
          epc_q    <= wb_bus.in_delay_slot ? (wb_bus.exception_pc - 32'd4)
                                           : wb_bus.exception_pc;
          cause_bd <= wb_bus.in_delay_slot;
        end
        cause_exc  <= wb_bus.exception_code;
        status_exl <= 1'b1;
        if (is_addr_error(wb_bus.exception_code)) begin
          badvaddr_q <= wb_bus.bad_vaddr;
        end
      end else begin
        if (wb_bus.eret_flush) begin
          status_exl <= 1'b0;
        end else if (write_status) begin
          status_im  <= wb_bus.write_data[STATUS_IM_LSB +: IP_W];
          status_exl <= wb_bus.write_data[STATUS_EXL_BIT];
          status_ie  <= wb_bus.write_data[STATUS_IE_BIT];
        end
        if (write_cause) begin
          sw_ip <= wb_bus.write_data[CAUSE_IP_LSB +: 2];
        end
        if (write_epc) begin
          epc_q <= wb_bus.write_data;
        end
      end
    end
  end

  // Architectural views assembled from the registered fields
  always_comb begin
    status       = '0;
    status.bev   = 1'b1;
    status.im    = status_im;
    status.exl   = status_exl;
    status.ie    = status_ie;

    cause          = '0;
    cause.bd       = cause_bd;
    cause.ti       = timer_interrupt;
    cause.ip       = {hw_ip[5] | timer_interrupt, hw_ip[4:0], sw_ip};
    cause.exc_code = cause_exc;

    epc    = '0;
    epc.pc = epc_q;
  end

  assign interrupt_pending = (|(cause.ip & status.im)) & status.ie & ~status.exl;

  always_comb begin
    read_data = '0;
    if (read_select == '0) begin
      case (read_register)
        CP0_BADVADDR: read_data = badvaddr_q;
        CP0_COUNT:    read_data = count_value;
        CP0_COMPARE:  read_data = compare_value;
        CP0_STATUS:   read_data = DATA_W'(status);
        CP0_CAUSE:    read_data = DATA_W'(cause);
        CP0_EPC:      read_data = epc_q;
        default:      read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_coprocessor0_regfile.sv
// Directed bench for coprocessor0_regfile; timer checks follow CP0_TIMER_EN.
module tb_coprocessor0_regfile;
  import coprocessor0_params::*;

  localparam int unsigned HW = 6;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  WBToCP0Bus   wb_bus;
  logic [HW-1:0] hardware_interrupt;
  logic [4:0]  read_register;
  logic [2:0]  read_select;
  logic [31:0] read_data;
  StatusData   status;
  CauseData    cause;
  EPCData      epc;
  logic        interrupt_pending;

  int checks = 0;
  int errors = 0;
  int n;

  coprocessor0_regfile #(
    .HW_INT_NUM  (HW),
    .COUNT_DIVIDE(2)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .wb_bus            (wb_bus),
    .hardware_interrupt(hardware_interrupt),
    .read_register     (read_register),
    .read_select       (read_select),
    .read_data         (read_data),
    .status            (status),
    .cause             (cause),
    .epc               (epc),
    .interrupt_pending (interrupt_pending)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reg(input string tag, input logic [4:0] r, input logic [2:0] s,
                           input logic [31:0] exp);
    read_register = r;
    read_select   = s;
    #1;
    check(tag, read_data, exp);
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    wb_bus.write_enabled    = 1'b1;
    wb_bus.address_register = r;
    wb_bus.address_select   = 3'd0;
    wb_bus.write_data       = d;
    tick();
    wb_bus = '0;
  endtask

  task automatic set_exception(input logic [4:0] code, input logic [31:0] pc,
                               input logic ds, input logic [31:0] bad);
    wb_bus.exception_valid = 1'b1;
    wb_bus.exception_code  = code;
    wb_bus.exception_pc    = pc;
    wb_bus.in_delay_slot   = ds;
    wb_bus.bad_vaddr       = bad;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_bus = '0;
    hardware_interrupt = '0;
    read_register = '0;
    read_select = '0;
    reset = 1'b1;
    tick();
    tick();
    check_reg("rst_status", CP0_STATUS, 3'd0, 32'h0040_0000);
    check_reg("rst_cause", CP0_CAUSE, 3'd0, 32'h0);
    check_reg("rst_epc", CP0_EPC, 3'd0, 32'h0);
    check_reg("rst_count", CP0_COUNT, 3'd0, 32'h0);
    check("rst_pending", 32'(interrupt_pending), 32'd0);
    reset = 1'b0;
    tick();

    // Move Compare out of reach so TI is clear for the interrupt checks
    mtc0(CP0_COMPARE, 32'hFFFF_0000);
    mtc0(CP0_STATUS, 32'h0000_FF01);
    check_reg("status_wr", CP0_STATUS, 3'd0, 32'h0040_FF01);
    check("pending_idle", 32'(interrupt_pending), 32'd0);

    hardware_interrupt = 6'b000001;
    tick();
    check_reg("cause_hw0", CP0_CAUSE, 3'd0, 32'h0000_0400);
    check("pending_hw0", 32'(interrupt_pending), 32'd1);
    check_reg("unmapped_sel", CP0_STATUS, 3'd1, 32'h0);
    check_reg("unmapped_reg", 5'd5, 3'd0, 32'h0);

    hardware_interrupt = 6'b100000;
    tick();
    check_reg("cause_hw5_ip7", CP0_CAUSE, 3'd0, 32'h0000_8000);
    hardware_interrupt = '0;
    tick();
    check("pending_clear", 32'(interrupt_pending), 32'd0);

    mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
    check_reg("cause_sw_ip", CP0_CAUSE, 3'd0, 32'h0000_0300);
    check("pending_sw_ip", 32'(interrupt_pending), 32'd1);
    mtc0(CP0_CAUSE, 32'h0);
    mtc0(CP0_STATUS, 32'hFFFF_FFFF);
    check_reg("status_mask", CP0_STATUS, 3'd0, 32'h0040_FF03);
    mtc0(CP0_STATUS, 32'h0000_FF01);

    // AdEL in a delay slot with EXL clear
    set_exception(EXC_ADEL, 32'hBFC0_0100, 1'b1, 32'h1234_5671);
    tick();
    wb_bus = '0;
    check_reg("exc1_epc", CP0_EPC, 3'd0, 32'hBFC0_00FC);
    check_reg("exc1_cause", CP0_CAUSE, 3'd0, 32'h8000_0010);
    check_reg("exc1_badvaddr", CP0_BADVADDR, 3'd0, 32'h1234_5671);
    check("exc1_epc_port", epc.pc, 32'hBFC0_00FC);
    check("exc1_status", 32'(status), 32'h0040_FF03);

    // Nested exception: EPC and BD held, code updated, BadVAddr untouched
    set_exception(EXC_OV, 32'h0000_0200, 1'b0, 32'hAAAA_0000);
    tick();
    wb_bus = '0;
    check_reg("exc2_epc", CP0_EPC, 3'd0, 32'hBFC0_00FC);
    check_reg("exc2_cause", CP0_CAUSE, 3'd0, 32'h8000_0030);
    check_reg("exc2_badvaddr", CP0_BADVADDR, 3'd0, 32'h1234_5671);

    wb_bus.eret_flush = 1'b1;
    tick();
    wb_bus = '0;
    check("eret_status", 32'(status), 32'h0040_FF01);

    // Exception beats a same-cycle mtc0 to EPC
    set_exception(EXC_SYS, 32'h0040_0020, 1'b0, 32'h0);
    wb_bus.write_enabled    = 1'b1;
    wb_bus.address_register = CP0_EPC;
    wb_bus.write_data       = 32'hDEAD_BEEF;
    tick();
    wb_bus = '0;
    check_reg("exc3_epc", CP0_EPC, 3'd0, 32'h0040_0020);
    check_reg("exc3_cause", CP0_CAUSE, 3'd0, 32'h0000_0020);
    check("exc3_status", 32'(status), 32'h0040_FF03);

    // eret beats mtc0 Status, but not mtc0 to a different register
    wb_bus.eret_flush       = 1'b1;
    wb_bus.write_enabled    = 1'b1;
    wb_bus.address_register = CP0_STATUS;
    wb_bus.write_data       = 32'h0;
    tick();
    wb_bus = '0;
    check("eret_vs_status", 32'(status), 32'h0040_FF01);
    wb_bus.eret_flush       = 1'b1;
    wb_bus.write_enabled    = 1'b1;
    wb_bus.address_register = CP0_EPC;
    wb_bus.write_data       = 32'h0000_1000;
    tick();
    wb_bus = '0;
    check_reg("eret_with_epc", CP0_EPC, 3'd0, 32'h0000_1000);
    mtc0(CP0_BADVADDR, 32'h0);
    check_reg("badvaddr_ro", CP0_BADVADDR, 3'd0, 32'h1234_5671);

`ifdef CP0_TIMER_EN
    mtc0(CP0_COMPARE, 32'd5);
    mtc0(CP0_COUNT, 32'd0);
    check_reg("count_wr", CP0_COUNT, 3'd0, 32'd0);
    n = 0;
    while (cause.ti !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
    check("ti_latency", 32'(n), 32'd11);
    check("ti_pending", 32'(interrupt_pending), 32'd1);
    check_reg("compare_rd", CP0_COMPARE, 3'd0, 32'd5);
    mtc0(CP0_COMPARE, 32'hFFFF_0000);
    check("ti_cleared", 32'(cause.ti), 32'd0);
    check("ti_pending_clr", 32'(interrupt_pending), 32'd0);
    mtc0(CP0_COUNT, 32'hFFFF_FFFF);
    check_reg("count_max", CP0_COUNT, 3'd0, 32'hFFFF_FFFF);
    tick();
    check_reg("count_prescale", CP0_COUNT, 3'd0, 32'hFFFF_FFFF);
    tick();
    check_reg("count_wrap", CP0_COUNT, 3'd0, 32'h0);
`else
    mtc0(CP0_COUNT, 32'd7);
    check_reg("count_absent", CP0_COUNT, 3'd0, 32'h0);
    mtc0(CP0_COMPARE, 32'd0);
    check_reg("compare_absent", CP0_COMPARE, 3'd0, 32'h0);
    repeat (20) tick();
    check("ti_absent", 32'(cause.ti), 32'd0);
`endif

    // Reset overrides a same-cycle exception and live interrupt lines
    hardware_interrupt = 6'b000001;
    set_exception(EXC_ADES, 32'h0000_4000, 1'b0, 32'h5555_AAAA);
    reset = 1'b1;
    tick();
    wb_bus = '0;
    hardware_interrupt = '0;
    check_reg("rst2_status", CP0_STATUS, 3'd0, 32'h0040_0000);
    check_reg("rst2_epc", CP0_EPC, 3'd0, 32'h0);
    check_reg("rst2_badvaddr", CP0_BADVADDR, 3'd0, 32'h0);
    check_reg("rst2_cause", CP0_CAUSE, 3'd0, 32'h0);
    check("rst2_pending", 32'(interrupt_pending), 32'd0);
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coprocessor0_regfile.md
# coprocessor0_regfile

Parametrised CP0 register file that holds the architectural state typed by the `coprocessor0_params` package: Status, Cause, EPC, BadVAddr and the Count/Compare timer. It sits beside the writeback stage. It takes mtc0 writes, exception and eret commits from writeback, and serves mfc0 reads. It also drives `interrupt_pending` to the exception logic. It adds the following over the plain data-type definitions:
- configurable hardware-interrupt width,
- a timer with a configurable prescaler,
- BadVAddr capture,
- nested-exception (EXL) handling.

## Interface
- `HW_INT_NUM`, 6: number of hardware interrupt lines, 1..6; they map to Cause.IP[2+HW_INT_NUM-1:2], and unused IP bits read 0.
- `COUNT_DIVIDE`, 2: clock cycles per Count increment, ≥1.
- `clock` in 1: only clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `wb_bus` in `WBToCP0Bus`: mtc0 and commit information from writeback.
- `hardware_interrupt` in HW_INT_NUM: level-sensitive external interrupts.
- `read_register` in 5: mfc0 register number.
- `read_select` in 3: mfc0 select.
- `read_data` out 32: combinational mfc0 result.
- `status` out `StatusData`: current Status.
- `cause` out `CauseData`: current Cause.
- `epc` out `EPCData`: current EPC, for the eret target.
- `interrupt_pending` out 1: a qualified interrupt is pending.

## Operation
- Registers (register,select). Only select 0 is mapped; any other select is unmapped.
  - BadVAddr (8,0): read-only.
  - Count (9,0).
  - Compare (11,0).
  - Status (12,0): writable bits are IM, EXL and IE; BEV is hardwired to 1.
  - Cause (13,0): only IP[1:0] is writable.
  - EPC (14,0).
- Reset values: all registers 0 except Status.BEV=1. Prescaler is 0. Therefore `interrupt_pending`=0.
- mtc0: when `write_enabled` is set, `write_data` commits to the addressed register at the clock edge. Writes to unmapped registers and read-only bits are ignored.
- Exception (`exception_valid`=1):
  - If Status.EXL=0:
    - EPC is set to `exception_pc`, or `exception_pc`−4 when `in_delay_slot`=1.
    - Cause.BD is set to `in_delay_slot`.
  - If Status.EXL=1, EPC and BD are held.
  - In both cases, Cause.ExcCode is set to `exception_code` and EXL is set to 1.
  - If `exception_code` is 4 or 5 (AdEL/AdES), BadVAddr is set to `bad_vaddr`.
- eret (`eret_flush`=1): EXL is cleared to 0.
- Priority in one cycle: exception > eret > mtc0. A lower-priority action is discarded only where it touches the same register.
- Hardware IP: each cycle, Cause.IP[2+i] is set to `hardware_interrupt[i]`. Cause.IP[7] is the OR of `hardware_interrupt[5]` (if present) and Cause.TI.
- `interrupt_pending` = |(Cause.IP & Status.IM) & Status.IE & ~Status.EXL. It is combinational from registered state.
- Timer:
  - The prescaler counts 0..COUNT_DIVIDE−1; Count increments when the prescaler wraps.
  - Count wraps from 0xFFFF_FFFF to 0.
  - Cause.TI is set on the cycle after Count equals Compare and stays set until Compare is written.
  - A Count write beats a same-cycle increment and resets the prescaler.
  - A Compare write clears TI, and wins over a same-cycle set.
- Reads: combinational from current state. An unmapped register returns 0. A same-cycle write is not visible (old value is returned).

## Timing
- mtc0 write or exception commit: visible on `read_data`/`status`/`cause`/`epc` 1 cycle later.
- `hardware_interrupt` to `interrupt_pending`: 1 cycle.
- Count==Compare to TI: 1 cycle. TI to `interrupt_pending` (IM7=1): 0 further cycles.
- Reset asserted mid-operation: all state returns to reset values at the next edge, regardless of other inputs.

## Configuration
- `CP0_TIMER_EN` defined: Count, Compare, the prescaler and TI are implemented as above.
- `CP0_TIMER_EN` undefined: Count and Compare read 0 and writes to them are ignored; TI is constant 0; IP[7] is driven by `hardware_interrupt[5]` only. `COUNT_DIVIDE` is unused.

## Structure
- `coprocessor0_params` gains the following; StatusData, CauseData and EPCData are reused.
  - `WBToCP0Bus`: address_register[4:0], address_select[2:0], write_enabled, write_data, exception_valid, eret_flush, exception_code[4:0], in_delay_slot, exception_pc, bad_vaddr.
  - Register-number localparams: CP0_BADVADDR=8, CP0_COUNT=9, CP0_COMPARE=11, CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14.
  - Exception-code constants: EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_SYS=8, EXC_BP=9, EXC_RI=10, EXC_OV=12.
- One sub-module, `coprocessor0_timer`: prescaler, Count, Compare and TI. It is instantiated only under `CP0_TIMER_EN`.

## Test plan
- Reset: read Status gives 0x0040_0000; Cause, EPC and Count read 0; `interrupt_pending`=0.
- mtc0 Status=0x0000_FF01, then `hardware_interrupt[0]`=1: Cause.IP reads 0x04 one cycle later, and `interrupt_pending`=1 on that same cycle.
- Exception with code 4, pc 0xBFC0_0100, `in_delay_slot`=1, bad_vaddr 0x1234_5671 → EPC=0xBFC0_00FC, BD=1, ExcCode=4, BadVAddr=0x1234_5671, EXL=1. A second exception at pc 0x200 leaves EPC unchanged. eret → EXL=0.
- Same-cycle exception and mtc0 EPC=0xDEAD_BEEF → EPC takes the exception value.
- Timer (COUNT_DIVIDE=2): write Compare=5, Count=0 → TI=1 about 11 cycles later. Write Compare → TI=0. Count=0xFFFF_FFFF wraps to 0.
- Built without `CP0_TIMER_EN`: write Count=7 → read 0; TI never sets.
